// File: rtl/alu_mc.sv
// Multi-cycle execute ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one edge; MUL/DIVU/REMU iterate CPU_WIDTH times.
module alu_mc #(
    parameter int CPU_WIDTH    = 32,
    parameter int ALU_OP_WIDTH = 4,
    localparam int SHAMT_W     = $clog2(CPU_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [CPU_WIDTH-1:0]    alu_src1,
    input  logic [CPU_WIDTH-1:0]    alu_src2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CPU_WIDTH-1:0]    alu_res,
    output logic                    zero
);

    localparam int W     = CPU_WIDTH;
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_MUL  = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_DIVU = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] OP_REMU = ALU_OP_WIDTH'(12);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_q, rem_q;
    logic [W-1:0]     acc_q, opa_q, opb_q;
    logic [W-1:0]     res_q;
    logic             zero_q, out_valid_q, in_ready_q;

    logic             accept, is_mul, is_div, is_rem, div_zero, is_iter;
    logic [SHAMT_W-1:0] shamt;
    logic [W-1:0]     single_res;
    logic [W-1:0]     mul_acc_n;
    logic [W:0]       rem_sh;
    logic             rem_ge;
    logic [W-1:0]     div_rem_n, div_quot_n, iter_res;
    logic             last;

    assign accept   = in_ready_q & in_valid;
    assign is_mul   = (alu_op == OP_MUL);
    assign is_div   = (alu_op == OP_DIVU);
    assign is_rem   = (alu_op == OP_REMU);
    assign div_zero = (alu_src2 == '0);
    assign is_iter  = is_mul | ((is_div | is_rem) & ~div_zero);
    assign shamt    = alu_src2[SHAMT_W-1:0];

    // Divide-by-zero results are produced here so they bypass BUSY.
    always_comb begin
        single_res = '0;
        unique case (alu_op)
            OP_ADD:  single_res = alu_src1 + alu_src2;
            OP_SUB:  single_res = alu_src1 - alu_src2;
            OP_AND:  single_res = alu_src1 & alu_src2;
            OP_OR:   single_res = alu_src1 | alu_src2;
            OP_XOR:  single_res = alu_src1 ^ alu_src2;
            OP_SLL:  single_res = alu_src1 << shamt;
            OP_SRL:  single_res = alu_src1 >> shamt;
            OP_SRA:  single_res = W'($signed(alu_src1) >>> shamt);
            OP_SLT:  single_res = W'($signed(alu_src1) < $signed(alu_src2));
            OP_SLTU: single_res = W'(alu_src1 < alu_src2);
            OP_DIVU: single_res = '1;
            OP_REMU: single_res = alu_src1;
            default: single_res = '0;
        endcase
    end

    // MUL: acc += mcand when mplier LSB set. DIV: acc=rem, opa=divisor, opb=quot.
    assign mul_acc_n  = acc_q + (opb_q[0] ? opa_q : '0);
    assign rem_sh     = {acc_q, opb_q[W-1]};
    assign rem_ge     = (rem_sh >= {1'b0, opa_q});
    assign div_rem_n  = rem_ge ? W'(rem_sh - {1'b0, opa_q}) : rem_sh[W-1:0];
    assign div_quot_n = {opb_q[W-2:0], rem_ge};
    assign iter_res   = mul_q ? mul_acc_n : (rem_q ? div_rem_n : div_quot_n);
    assign last       = (cnt_q == CNT_W'(1));

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: if (accept) state_n = is_iter ? BUSY : DONE;
            BUSY: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            rem_q       <= 1'b0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_n;
            out_valid_q <= (state_n == DONE);
            in_ready_q  <= (state_n == IDLE);
            unique case (state_q)
                IDLE: begin
                    if (accept && is_iter) begin
                        cnt_q <= CNT_W'(W);
                        mul_q <= is_mul;
                        rem_q <= is_rem;
                        acc_q <= '0;
                        opa_q <= is_mul ? alu_src1 : alu_src2;
                        opb_q <= is_mul ? alu_src2 : alu_src1;
                    end else if (accept) begin
                        res_q  <= single_res;
                        zero_q <= (single_res == '0);
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (mul_q) begin
                        acc_q <= mul_acc_n;
                        opa_q <= opa_q << 1;
                        opb_q <= opb_q >> 1;
                    end else begin
                        acc_q <= div_rem_n;
                        opb_q <= div_quot_n;
                    end
                    if (last) begin
                        res_q  <= iter_res;
                        zero_q <= (iter_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_res   = res_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc.
// Latency counts edges from the accept edge to the edge raising out_valid.
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_res;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.CPU_WIDTH(32), .ALU_OP_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_res   (alu_res),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1, check result, zero and latency.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic busy_ok;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        alu_op   = op;
        alu_src1 = a;
        alu_src2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 4'd1;
        alu_src1 = 32'hDEADBEEF;
        alu_src2 = 32'h0BADF00D;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, alu_res, exp_res);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        check({tag, "_busy_stall"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 4'd0;
        alu_src1  = 32'd0;
        alu_src2  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_res", alu_res, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
        run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
        run_op("and", 4'd2, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1);
        run_op("or", 4'd3, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1);
        run_op("xor", 4'd4, 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0, 1);
        run_op("sll", 4'd5, 32'h1, 32'h3F, 32'h80000000, 1);
        run_op("srl", 4'd6, 32'h80000000, 32'h4, 32'h08000000, 1);
        run_op("sra", 4'd7, 32'h80000000, 32'h21, 32'hC0000000, 1);
        run_op("slt", 4'd8, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
        run_op("sltu", 4'd9, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
        run_op("op14", 4'd14, 32'h12345678, 32'h9, 32'h0, 1);
        run_op("mul", 4'd10, 32'h00010001, 32'h00010001, 32'h00020001, 33);
        run_op("mul_neg", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33);
        run_op("divu", 4'd11, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu", 4'd12, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_max", 4'd11, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 33);
        run_op("remu_zero", 4'd12, 32'd21, 32'd7, 32'd0, 33);
        run_op("divu_by0", 4'd11, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
        run_op("remu_by0", 4'd12, 32'd9, 32'd0, 32'd9, 1);

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        alu_op    = 4'd0;
        alu_src1  = 32'd3;
        alu_src2  = 32'd4;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        alu_src1 = 32'd1;
        alu_src2 = 32'd1;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_res", alu_res, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_res", alu_res, 32'd7);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_res", alu_res, 32'd2);
        @(posedge clk);
        #1;

        // Reset during MUL abandons it.
        alu_op   = 4'd10;
        alu_src1 = 32'd6;
        alu_src2 = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_res", alu_res, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("mid_rst_no_output", 32'(seen), 32'd0);
        run_op("post_rst_add", 4'd0, 32'd10, 32'd20, 32'd30, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU and successor to the single-cycle execute ALU. It adds logic, shift, compare, iterative multiply and unsigned divide/remainder operations, plus valid/ready handshakes on both sides. It sits in the execute stage and stalls the pipeline through in_ready/out_valid while an iterative operation runs. All outputs are registered.

Parameters:
CPU_WIDTH, 32, operand/result width; power of two, >= 8
ALU_OP_WIDTH, 4, opcode width; must be >= 4
SHAMT_W, $clog2(CPU_WIDTH), derived shift-amount width; not overridden by users

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
alu_op  input  ALU_OP_WIDTH  opcode, sampled on accept
alu_src1  input  CPU_WIDTH  source 1, sampled on accept
alu_src2  input  CPU_WIDTH  source 2, sampled on accept
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
alu_res  output  CPU_WIDTH  result
zero  output  1  alu_res == 0

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk. Reset forces state=IDLE, out_valid=0, alu_res=0, zero=0 and clears the internal counter/accumulators. Reset mid-operation abandons the operation with no output.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low CPU_WIDTH bits of the product), 11 DIVU, 12 REMU. Codes 13..max give alu_res=0 with latency 1.
- Shifts use only alu_src2[SHAMT_W-1:0]; the upper bits are ignored. All arithmetic wraps modulo 2^CPU_WIDTH.
- zero is registered together with alu_res and equals (alu_res==0) for every opcode.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: an iterative op is running; in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE & in_valid & single-cycle op -> DONE. The result is computed from the sampled operands and registered on the same edge, so out_valid rises 1 cycle after accept.
  - IDLE & in_valid & op 10/11/12 -> BUSY with the counter loaded to CPU_WIDTH.
  - BUSY: one iteration per cycle; the counter decrements. When the counter reaches 0, go to DONE with the result registered. out_valid rises CPU_WIDTH+1 cycles after accept.
  - DONE & out_ready -> IDLE. DONE & !out_ready -> hold; alu_res and zero stay stable.
- MUL uses shift-add: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
- DIVU/REMU use restoring division: shift {rem,quot} left; if rem >= divisor, subtract and set the quotient LSB.
- Divide by zero skips BUSY and goes straight to DONE (latency 1). DIVU returns all ones; REMU returns alu_src1.
- in_valid while in_ready=0 is ignored; the requester holds it. Operand changes after accept have no effect.
- The minimum issue interval is 2 cycles: accept, then DONE & out_ready, then IDLE.

Test Plan:
- Reset released, no stimulus -> out_valid=0, alu_res=0, zero=0, in_ready=1. Assert rst_n=0 during a MUL in BUSY -> next cycle state=IDLE, out_valid=0.
- ADD 0xFFFFFFFF+1 -> out_valid 1 cycle after accept, alu_res=0, zero=1. SUB 5-7 -> 0xFFFFFFFE, zero=0. SRA 0x80000000 by src2=0x21 -> shift by 1, result 0xC0000000.
- SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0. Opcode 14 -> alu_res=0, zero=1.
- MUL 0x00010001*0x00010001 -> out_valid exactly 33 cycles after accept, alu_res=0x00020001. in_ready=0 throughout.
- DIVU 100/7 -> 14. REMU 100/7 -> 2, latency 33. DIVU 9/0 -> 0xFFFFFFFF and REMU 9/0 -> 9, both latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> alu_res stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> IDLE next cycle, and the next request is accepted.
